// File: rtl/idex_pipe_stage.sv
// ID/EX pipeline register with valid/ready handshake, 2-entry skid buffer and synchronous flush.
// Optional stall counter is enabled by defining IDEX_STALL_CNT_EN.
module idex_pipe_stage #(
    parameter int unsigned OP_W  = 5,
    parameter int unsigned REG_W = 9,
    parameter int unsigned IMM_W = 20,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_opcode,
    input  logic [REG_W-1:0] in_rd,
    input  logic [REG_W-1:0] in_rs,
    input  logic [REG_W-1:0] in_rt,
    input  logic [IMM_W-1:0] in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OP_W-1:0]  out_opcode,
    output logic [REG_W-1:0] out_rd,
    output logic [REG_W-1:0] out_rs,
    output logic [REG_W-1:0] out_rt,
    output logic [IMM_W-1:0] out_imm
`ifdef IDEX_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam int unsigned PW = OP_W + 3 * REG_W + IMM_W;

    // Bit 0 = main valid, bit 1 = skid valid, so both flags come straight from flops.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StTwo   = 2'b11
    } state_e;

    state_e state_q, state_d;

    logic [PW-1:0] in_pay;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;

    logic acc, take;
    logic load_main, load_skid, main_from_skid;

    assign in_pay = {in_opcode, in_rd, in_rs, in_rt, in_imm};
    assign acc    = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: if (acc) state_d = StOne;
                StOne: begin
                    if (take && !acc) begin
                        state_d = StEmpty;
                    end else if (!take && acc) begin
                        state_d = StTwo;
                    end
                end
                StTwo: if (take) state_d = StOne;
                default: state_d = StEmpty;
            endcase
        end
    end

    always_comb begin
        in_ready       = ~state_q[1];
        out_valid      = state_q[0];
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        // Flush leaves payload untouched; only the valid state is cleared.
        if (!flush) begin
            unique case (state_q)
                StEmpty: load_main = acc;
                StOne: begin
                    load_main = take & acc;
                    load_skid = ~take & acc;
                end
                StTwo: begin
                    load_main      = take;
                    main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (load_main) main_d = main_from_skid ? skid_q : in_pay;
        if (load_skid) skid_d = in_pay;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign {out_opcode, out_rd, out_rs, out_rt, out_imm} = main_q;

`ifdef IDEX_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Only reset clears the counter; flush does not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_idex_pipe_stage.sv
// Randomized plus directed bench for idex_pipe_stage against a queue-based transaction model.
// Defining IDEX_STALL_CNT_EN also checks the stall counter, including a 2-bit saturating copy.
module tb_idex_pipe_stage;

    localparam int unsigned OP_W  = 5;
    localparam int unsigned REG_W = 9;
    localparam int unsigned IMM_W = 20;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned PW    = OP_W + 3 * REG_W + IMM_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_opcode;
    logic [REG_W-1:0] in_rd, in_rs, in_rt;
    logic [IMM_W-1:0] in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [OP_W-1:0]  out_opcode;
    logic [REG_W-1:0] out_rd, out_rs, out_rt;
    logic [IMM_W-1:0] out_imm;
`ifdef IDEX_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic             in_ready2, out_valid2;
    logic [OP_W-1:0]  out_opcode2;
    logic [REG_W-1:0] out_rd2, out_rs2, out_rt2;
    logic [IMM_W-1:0] out_imm2;
    logic [1:0]       stall_cnt2;
`endif

    always #5 clk = ~clk;

    idex_pipe_stage #(
        .OP_W (OP_W),
        .REG_W(REG_W),
        .IMM_W(IMM_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_opcode(out_opcode),
        .out_rd    (out_rd),
        .out_rs    (out_rs),
        .out_rt    (out_rt),
        .out_imm   (out_imm)
`ifdef IDEX_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

`ifdef IDEX_STALL_CNT_EN
    idex_pipe_stage #(
        .OP_W (OP_W),
        .REG_W(REG_W),
        .IMM_W(IMM_W),
        .CNT_W(2)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_imm    (in_imm),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .out_opcode(out_opcode2),
        .out_rd    (out_rd2),
        .out_rs    (out_rs2),
        .out_rt    (out_rt2),
        .out_imm   (out_imm2),
        .stall_cnt (stall_cnt2)
    );
`endif

    // Reference model: the instructions currently held, oldest first.
    logic [PW-1:0] mq[$];
    longint unsigned stall_model;
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input int op, input int rd, input int rs, input int rt,
                                          input int imm);
        return {OP_W'(op), REG_W'(rd), REG_W'(rs), REG_W'(rt), IMM_W'(imm)};
    endfunction

    function automatic longint unsigned sat(input longint unsigned v, input int bits);
        longint unsigned mx;
        mx = (64'd1 << bits) - 64'd1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_outputs();
        check_eq("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        check_eq("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            check_eq("out_payload", 64'({out_opcode, out_rd, out_rs, out_rt, out_imm}), 64'(mq[0]));
        end
`ifdef IDEX_STALL_CNT_EN
        check_eq("stall_cnt", 64'(stall_cnt), sat(stall_model, int'(CNT_W)));
        check_eq("stall_cnt_sat2", 64'(stall_cnt2), sat(stall_model, 2));
        check_eq("out_valid_sat2", 64'(out_valid2), 64'(mq.size() > 0));
`endif
    endtask

    // One clock: check state at negedge, drive inputs, advance the model at the posedge.
    task automatic cycle(input logic v, input logic [PW-1:0] p, input logic ordy, input logic fl);
        logic exp_rdy, take, acc;
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        {in_opcode, in_rd, in_rs, in_rt, in_imm} = p;
        out_ready = ordy;
        flush     = fl;
        exp_rdy   = (mq.size() < 2);
        take      = (mq.size() > 0) && ordy;
        acc       = v && exp_rdy;
        @(posedge clk);
        if ((mq.size() > 0) && !ordy) stall_model++;
        if (fl) begin
            mq.delete();
        end else begin
            if (take) void'(mq.pop_front());
            if (acc) mq.push_back(p);
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, ordy, 1'b0);
    endtask

    initial begin
        logic [PW-1:0] rp;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        {in_opcode, in_rd, in_rs, in_rt, in_imm} = '0;
        stall_model = 0;
        repeat (2) @(negedge clk);
        check_eq("reset_out_valid", 64'(out_valid), 64'd0);
        check_eq("reset_out_payload", 64'({out_opcode, out_rd, out_rs, out_rt, out_imm}), 64'd0);
        check_eq("reset_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // Stream with execute always ready.
        cycle(1'b1, mk(3, 1, 2, 3, 11), 1'b1, 1'b0);
        cycle(1'b1, mk(11, 6, 9, 8, 14), 1'b1, 1'b0);
        cycle(1'b1, mk(7, 9, 7, 5, 128), 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Backpressure fills the skid, then drains in order.
        cycle(1'b1, mk(3, 4, 5, 6, 7), 1'b0, 1'b0);
        cycle(1'b1, mk(11, 1, 1, 1, 1), 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush in TWO with concurrent in_valid, then flush in ONE racing an acceptance.
        cycle(1'b1, mk(1, 2, 3, 4, 5), 1'b0, 1'b0);
        cycle(1'b1, mk(2, 3, 4, 5, 6), 1'b0, 1'b0);
        cycle(1'b1, mk(7, 0, 0, 0, 0), 1'b0, 1'b1);
        idle(1'b1);
        cycle(1'b1, mk(9, 9, 9, 9, 9), 1'b0, 1'b0);
        cycle(1'b1, mk(7, 1, 2, 3, 4), 1'b1, 1'b1);
        idle(1'b1);

        // Long stall: counter climbs past the 2-bit ceiling.
        cycle(1'b1, mk(5, 5, 5, 5, 5), 1'b0, 1'b0);
        repeat (6) idle(1'b0);
        idle(1'b1);

        // Simultaneous take and accept in ONE.
        cycle(1'b1, mk(4, 4, 4, 4, 4), 1'b1, 1'b0);
        cycle(1'b1, mk(6, 1, 2, 3, 128), 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // Asynchronous reset between edges while in ONE.
        cycle(1'b1, mk(13, 3, 3, 3, 99), 1'b0, 1'b0);
        @(negedge clk);
        check_outputs();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("async_rst_out_opcode", 64'(out_opcode), 64'd0);
        check_eq("async_rst_in_ready", 64'(in_ready), 64'd1);
        mq.delete();
        stall_model = 0;
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, mk(21, 7, 8, 9, 1000), 1'b1, 1'b0);
        idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rp = mk(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                    int'($urandom));
            cycle(1'($urandom_range(0, 3) != 0), rp, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0));
        end
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idex_pipe_stage.md
Name: idex_pipe_stage

Overview:
- Parametrised ID/EX pipeline register with a valid/ready handshake, a 2-entry skid buffer, and a synchronous flush.
- Carries opcode, destination and source register fields, and the immediate from decode to execute.
- Lets execute stall the pipeline without a combinational ready path back into decode.
- Sits between the decode stage and the ALU/execute stage.

Parameters:
- OP_W, 5, opcode width.
- REG_W, 9, width of each register field (rd, rs, rt).
- IMM_W, 20, immediate width.
- CNT_W, 16, stall counter width (used only with IDEX_STALL_CNT_EN).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous reset, active-high.
- flush  input  1  synchronous kill of all held instructions.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  stage can accept; driven from a register only.
- in_opcode  input  OP_W  opcode.
- in_rd  input  REG_W  destination register.
- in_rs  input  REG_W  source register 1.
- in_rt  input  REG_W  source register 2.
- in_imm  input  IMM_W  immediate.
- out_valid  output  1  execute-side instruction valid.
- out_ready  input  1  execute accepts.
- out_opcode  output  OP_W  registered opcode.
- out_rd  output  REG_W  registered rd.
- out_rs  output  REG_W  registered rs.
- out_rt  output  REG_W  registered rt.
- out_imm  output  IMM_W  registered immediate.
- stall_cnt  output  CNT_W  stall counter (IDEX_STALL_CNT_EN only).

Behaviour:
- Storage: main register (drives out_*) plus skid register, each with its own valid bit.
- in_ready = ~skid_valid.
- Handshakes:
  - acc = in_valid & in_ready.
  - take = out_valid & out_ready.
  - out_valid = main_valid.
- States: EMPTY (main invalid), ONE (main valid, skid empty), TWO (both valid). Transitions per rising edge, flush=0:
  - EMPTY: acc → load main, go ONE. Otherwise stay.
  - ONE, take & acc: reload main with input, stay ONE.
  - ONE, take & ~acc: go EMPTY.
  - ONE, ~take & acc: load skid, go TWO.
  - ONE, ~take & ~acc: hold.
  - TWO, take: skid moves to main, skid invalid, go ONE. in_ready is 0 in TWO, so acc cannot occur.
  - TWO, ~take: hold all.
- Latency: input accepted at edge N is visible on out_* after edge N, one cycle, when the stage was EMPTY or ONE with take.
- Ordering is strictly FIFO; no instruction is duplicated or dropped except on flush.
- Payload registers are never written when not loading; out_* holds stable while out_valid=1 and out_ready=0.
- Flush:
  - At the edge, both valid bits clear and state goes to EMPTY.
  - Flush has priority over a simultaneous acc: that instruction is discarded.
  - take in the same cycle is still consumed normally by execute; the stage simply does not retain it.
  - Payload data is left as is.
  - in_ready is 1 in the next cycle.
- Reset, asynchronous, any time including mid-transfer:
  - Both valids 0, all payload registers 0, state EMPTY.
  - out_valid=0, out_* = 0, in_ready=1, stall_cnt=0.
  - First acceptance is possible on the first edge after rst deasserts.
- Ready and valid flags in the same cycle are independent; no combinational path from out_ready to in_ready.

Optional Feature:
- Macro IDEX_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 on each edge where out_valid=1 and out_ready=0, saturating at 2^CNT_W-1.
  - Flush does not clear it; only rst does.
- Undefined: stall_cnt port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset then stream, out_ready=1:
  - Stimulus: {op=3, rd=1, rs=2, rt=3, imm=11} then {11, 6, 9, 8, 14} then {7, 9, 7, 5, 128} on consecutive edges.
  - Required: each appears on out_* exactly one cycle after acceptance, in order; in_ready stays 1.
- Backpressure:
  - Stimulus: out_ready=0 while sending op=3 then op=11.
  - Required: out shows op=3 held stable; op=11 goes to the skid; in_ready=0 the following cycle.
  - Then raise out_ready for 2 cycles. Required: op=3 then op=11 delivered, in_ready returns to 1, no loss or duplicate.
- Flush in TWO with a concurrent in_valid:
  - Stimulus: flush=1 with in_valid=1, op=7.
  - Required: next cycle out_valid=0, in_ready=1, and op=7 is never emitted.
- Async reset mid-stream:
  - Stimulus: assert rst between edges while in ONE.
  - Required: out_valid=0 and out_opcode=0 immediately, without waiting for a clock edge.
- Stall counter, with IDEX_STALL_CNT_EN:
  - Stimulus: hold out_ready=0 for 5 cycles with out_valid=1.
  - Required: stall_cnt=5.
  - Stimulus: CNT_W=2 with a 6-cycle stall. Required: saturates at 3.
- Simultaneous take & acc in ONE:
  - Stimulus: out_ready=1 and in_valid=1 with imm=128.
  - Required: main is replaced in one edge, skid stays empty, out_imm=128 next cycle.
